// File: rtl/tetris_pkg.sv
// Shared colour codes, scheduler state encoding and board geometry for the
// board display slice.
package tetris_pkg;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] RED     = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] BLUE    = 3'b011;
    localparam logic [2:0] MAGENTA = 3'b100;
    localparam logic [2:0] CYAN    = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        GRD   = 2'd3
    } sched_state_t;

    localparam int         NCOLS     = 10;
    localparam logic [3:0] COLS      = 4'd10;
    localparam logic [4:0] ROWS      = 5'd20;
    localparam int         CELL_LOG2 = 4;
    localparam logic [9:0] ORIGIN_X  = 10'd240;
    localparam logic [9:0] ORIGIN_Y  = 10'd80;
    localparam logic [9:0] H_ACTIVE  = 10'd640;
    localparam logic [9:0] V_TOTAL   = 10'd525;
    localparam logic [9:0] BOARD_W   = {6'd0, COLS} << CELL_LOG2;
    localparam logic [9:0] BOARD_H   = {5'd0, ROWS} << CELL_LOG2;

    function automatic logic [7:0] cell_addr(input logic [4:0] row, input logic [3:0] col);
        return ({3'b000, row} * {4'b0000, COLS}) + {4'b0000, col};
    endfunction

endpackage

// File: rtl/board_line_buffer.sv
// One display line worth of cell colours: indexed write port, combinational
// read port, cleared by the asynchronous reset.
module board_line_buffer
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] wr_idx,
    input  logic [2:0] wr_data,
    input  logic [3:0] rd_idx,
    output logic [2:0] rd_data
);

    logic [2:0] lb_q [NCOLS];
    logic [2:0] lb_d [NCOLS];

    // Next-state for the entry being written.
    always_comb begin
        lb_d = lb_q;
        if (we && (wr_idx < COLS)) begin
            lb_d[wr_idx] = wr_data;
        end else begin
            lb_d = lb_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOLS; i++) begin
                lb_q[i] <= BLACK;
            end
        end else begin
            lb_q <= lb_d;
        end
    end

    assign rd_data = (rd_idx < COLS) ? lb_q[rd_idx] : BLACK;

endmodule

// File: rtl/board_display_scheduler.sv
// Arbitrates the board cell RAM between game logic and the line prefetcher,
// and produces the registered pixel colour. Define BOARD_GRID_EN for grid lines.
module board_display_scheduler
    import tetris_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    input  logic [2:0] ram_rdata,
    input  logic       gl_req,
    input  logic       gl_we,
    input  logic [4:0] gl_row,
    input  logic [3:0] gl_col,
    input  logic [2:0] gl_wdata,
    output logic       gl_ack,
    output logic [2:0] gl_rdata,
    output logic [2:0] Color,
    output logic       fetch_busy
);

    sched_state_t state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic [4:0]   row_q, row_d;
    logic         pending_q, pending_d;
    logic [2:0]   color_q, color_d;

    logic [9:0]   next_y_s;
    logic [9:0]   fetch_y_s;
    logic [4:0]   trig_row_s;
    logic         trig_s;
    logic         gl_oor_s;
    logic [9:0]   x_rel_s;
    logic         in_win_s;
    logic         lb_we_s;
    logic [3:0]   lb_widx_s;
    logic [3:0]   lb_ridx_s;
    logic [2:0]   lb_rdata_s;
`ifdef BOARD_GRID_EN
    logic [9:0]   y_rel_s;
`endif

    // Trigger at the start of h-blank when the upcoming scanline is on the board.
    always_comb begin
        next_y_s   = (DrawY == (V_TOTAL - 10'd1)) ? 10'd0 : (DrawY + 10'd1);
        fetch_y_s  = next_y_s - ORIGIN_Y;
        trig_row_s = 5'(fetch_y_s >> CELL_LOG2);
        trig_s     = (DrawX == H_ACTIVE) && (next_y_s >= ORIGIN_Y)
                     && (next_y_s < (ORIGIN_Y + BOARD_H));
        gl_oor_s   = (gl_row >= ROWS) || (gl_col >= COLS);
    end

    // Scheduler: a pending or same-cycle trigger wins over a game request in IDLE.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_d     = trig_s ? trig_row_s : row_q;
        pending_d = pending_q | trig_s;
        ram_addr  = 8'd0;
        ram_we    = 1'b0;
        ram_wdata = 3'b000;
        gl_ack    = 1'b0;
        gl_rdata  = 3'b000;
        lb_we_s   = 1'b0;
        lb_widx_s = 4'd0;
        case (state_q)
            IDLE: begin
                if (pending_q || trig_s) begin
                    state_d   = FETCH;
                    k_d       = 4'd0;
                    pending_d = 1'b0;
                end else if (gl_req && Reset_n) begin
                    // Game service is gated by reset so no strobe escapes while held.
                    if (gl_oor_s) begin
                        gl_ack = 1'b1;
                    end else if (gl_we) begin
                        ram_we    = 1'b1;
                        ram_addr  = cell_addr(gl_row, gl_col);
                        ram_wdata = gl_wdata;
                        gl_ack    = 1'b1;
                    end else begin
                        ram_addr = cell_addr(gl_row, gl_col);
                        state_d  = GRD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRD: begin
                gl_ack   = 1'b1;
                gl_rdata = ram_rdata;
                state_d  = IDLE;
            end
            FETCH: begin
                ram_addr = cell_addr(row_q, k_q);
                if (k_q != 4'd0) begin
                    lb_we_s   = 1'b1;
                    lb_widx_s = k_q - 4'd1;
                end else begin
                    lb_we_s = 1'b0;
                end
                if (k_q == (COLS - 4'd1)) begin
                    state_d = DRAIN;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DRAIN: begin
                lb_we_s   = 1'b1;
                lb_widx_s = COLS - 4'd1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel colour lookup from the line buffer.
    always_comb begin
        x_rel_s   = DrawX - ORIGIN_X;
        lb_ridx_s = 4'(x_rel_s >> CELL_LOG2);
        in_win_s  = (DrawX >= ORIGIN_X) && (DrawX < (ORIGIN_X + BOARD_W))
                    && (DrawY >= ORIGIN_Y) && (DrawY < (ORIGIN_Y + BOARD_H));
`ifdef BOARD_GRID_EN
        y_rel_s   = DrawY - ORIGIN_Y;
`endif
        color_d   = BLACK;
        if (in_win_s) begin
            color_d = lb_rdata_s;
`ifdef BOARD_GRID_EN
            if ((lb_rdata_s == BLACK)
                && ((x_rel_s[CELL_LOG2-1:0] == 4'd0) || (y_rel_s[CELL_LOG2-1:0] == 4'd0))) begin
                color_d = WHITE;
            end else begin
                color_d = lb_rdata_s;
            end
`endif
        end else begin
            color_d = BLACK;
        end
    end

    // State, fetch cursor and pixel output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            k_q       <= 4'd0;
            row_q     <= 5'd0;
            pending_q <= 1'b0;
            color_q   <= BLACK;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            row_q     <= row_d;
            pending_q <= pending_d;
            color_q   <= color_d;
        end
    end

    board_line_buffer u_line_buffer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .we      (lb_we_s),
        .wr_idx  (lb_widx_s),
        .wr_data (ram_rdata),
        .rd_idx  (lb_ridx_s),
        .rd_data (lb_rdata_s)
    );

    assign Color      = color_q;
    assign fetch_busy = (state_q == FETCH) || (state_q == DRAIN);

endmodule

// File: tb/tb_board_display_scheduler.sv
// Scoreboard bench for board_display_scheduler with a behavioural cell RAM.
`timescale 1ns/1ps
module tb_board_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] draw_x, draw_y;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata = 3'b000;
    logic       gl_req, gl_we;
    logic [4:0] gl_row;
    logic [3:0] gl_col;
    logic [2:0] gl_wdata;
    logic       gl_ack;
    logic [2:0] gl_rdata;
    logic [2:0] color;
    logic       fetch_busy;

    typedef struct packed { logic chk; logic [2:0] d; } gl_exp_t;
    typedef struct { int x; int y; logic [2:0] c; } pix_exp_t;

    gl_exp_t    sb_gl[$];
    pix_exp_t   sb_pix[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         we_cnt = 0;
    logic       mem_clr = 1'b1;
    logic       pix_probe = 1'b0;
    logic       pix_probe_q = 1'b0;
    logic [2:0] mem [200];
    logic [2:0] ex_board [200];
    logic [2:0] exp_lb [10];
    logic [2:0] vals0 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
    logic [2:0] vals1 [10] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd7, 3'd6, 3'd5};

    board_display_scheduler dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .gl_req     (gl_req),
        .gl_we      (gl_we),
        .gl_row     (gl_row),
        .gl_col     (gl_col),
        .gl_wdata   (gl_wdata),
        .gl_ack     (gl_ack),
        .gl_rdata   (gl_rdata),
        .Color      (color),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    // Single-port cell RAM: write-through on ram_we, registered read data.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 200; i++) mem[i] <= 3'b000;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Game-port responses are matched in issue order.
    always @(negedge clk) begin
        if (ram_we === 1'b1) we_cnt++;
        if (gl_ack === 1'b1) begin
            if (sb_gl.size() == 0) begin
                chk("gl_ack_unexpected", 32'd1, 32'd0);
            end else begin
                gl_exp_t e;
                e = sb_gl.pop_front();
                if (e.chk) chk("gl_rdata", 32'(gl_rdata), 32'(e.d));
            end
        end
    end

    // Colour probes retire one cycle after the pixel was presented.
    always @(posedge clk) pix_probe_q <= pix_probe;

    always @(negedge clk) begin
        if (pix_probe_q) begin
            if (sb_pix.size() == 0) begin
                chk("pix_sb_empty", 32'd1, 32'd0);
            end else begin
                pix_exp_t p;
                p = sb_pix.pop_front();
                chk($sformatf("color(%0d,%0d)", p.x, p.y), 32'(color), 32'(p.c));
            end
        end
    end

    function automatic logic [2:0] exp_pix(input int x, input int y);
        logic [2:0] c;
        if (x < 240 || x >= 400 || y < 80 || y >= 400) return 3'b000;
        c = exp_lb[(x - 240) / 16];
`ifdef BOARD_GRID_EN
        if (c == 3'b000 && (((x - 240) % 16) == 0 || ((y - 80) % 16) == 0)) return 3'b111;
`endif
        return c;
    endfunction

    // All tasks are entered and left 1 ns after a rising edge.
    task automatic pix(input int x, input int y, input logic [2:0] e);
        pix_exp_t p;
        p.x = x; p.y = y; p.c = e;
        sb_pix.push_back(p);
        draw_x = 10'(x);
        draw_y = 10'(y);
        pix_probe = 1'b1;
        @(posedge clk); #1;
        pix_probe = 1'b0;
        draw_x = 10'd0;
        draw_y = 10'd0;
        @(posedge clk); #1;
    endtask

    task automatic gl_txn(input string tag, input logic we, input int row, input int col,
                          input logic [2:0] wd, input int exp_lat);
        logic    inr;
        int      lat;
        gl_exp_t e;
        inr   = (row < 20) && (col < 10);
        e.chk = !we || !inr;
        e.d   = (inr && !we) ? ex_board[row * 10 + col] : 3'b000;
        sb_gl.push_back(e);
        if (we && inr) ex_board[row * 10 + col] = wd;
        gl_req   = 1'b1;
        gl_we    = we;
        gl_row   = 5'(row);
        gl_col   = 4'(col);
        gl_wdata = wd;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (we && inr) begin
                    chk({tag, "_we"}, 32'(ram_we), 32'd1);
                    chk({tag, "_addr"}, 32'(ram_addr), 32'(row * 10 + col));
                    chk({tag, "_wdata"}, 32'(ram_wdata), 32'(wd));
                end else begin
                    chk({tag, "_we"}, 32'(ram_we), 32'd0);
                end
            end
            if (gl_ack === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_ack_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        gl_req = 1'b0;
        gl_we  = 1'b0;
    endtask

    task automatic busy_start(output int fs);
        fs = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fetch_busy === 1'b1) begin
                fs = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic trigger_line(input int y);
        draw_x = 10'd640;
        draw_y = 10'(y);
        @(posedge clk); #1;
        draw_x = 10'd0;
        draw_y = 10'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        int fs_a;
        int fs_b;
        int we_before;
        rst_n = 1'b0;
        draw_x = 10'd0; draw_y = 10'd0;
        gl_req = 1'b0; gl_we = 1'b0; gl_row = 5'd0; gl_col = 4'd0; gl_wdata = 3'd0;
        for (int i = 0; i < 200; i++) ex_board[i] = 3'b000;
        for (int i = 0; i < 10; i++) exp_lb[i] = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
        chk("rst_gl_ack", 32'(gl_ack), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_clr = 1'b0;
        @(posedge clk); #1;

        // Game write row 3 col 7 then read it back
        gl_txn("wr37", 1'b1, 3, 7, 3'b010, 0);
        gl_txn("rd37", 1'b0, 3, 7, 3'b000, 1);

        // Out-of-range requests: immediate ack, zero data, no RAM write
        we_before = we_cnt;
        gl_txn("oor_row", 1'b0, 20, 2, 3'b000, 0);
        gl_txn("oor_col", 1'b1, 4, 12, 3'b101, 0);
        chk("oor_no_ram_we", 32'(we_cnt - we_before), 32'd0);

        // Grid behaviour on an empty line buffer
`ifdef BOARD_GRID_EN
        pix(240, 80, 3'b111);
`else
        pix(240, 80, 3'b000);
`endif
        pix(241, 81, 3'b000);

        // Prefetch of row 0
        for (int c = 0; c < 10; c++) gl_txn("pre0", 1'b1, 0, c, vals0[c], 0);
        draw_x = 10'd640;
        draw_y = 10'd79;
        @(negedge clk);
        chk("busy_in_trigger_cycle", 32'(fetch_busy), 32'd0);
        @(posedge clk); #1;
        draw_x = 10'd0;
        draw_y = 10'd0;
        busy = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (fetch_busy === 1'b1) begin
                if (busy < 10) chk($sformatf("fetch_addr%0d", busy), 32'(ram_addr), 32'(busy));
                busy++;
            end
            @(posedge clk); #1;
        end
        chk("fetch_busy_cycles", 32'(busy), 32'd11);
        for (int c = 0; c < 10; c++) exp_lb[c] = ex_board[c];
        pix(240, 80, 3'b001);
        pix(399, 80, 3'b011);
        pix(400, 80, 3'b000);
        pix(256, 85, exp_pix(256, 85));
        pix(240, 79, 3'b000);

        // Read issued in the trigger cycle: fetch first (11 cycles), IDLE, then GRD
        draw_x = 10'd640;
        draw_y = 10'd80;
        fork
            gl_txn("coll_same", 1'b0, 3, 7, 3'b000, 13);
            begin @(posedge clk); #1; draw_x = 10'd0; draw_y = 10'd0; end
            busy_start(fs_a);
        join
        chk("coll_same_fetch_start", 32'(fs_a), 32'd1);

        // Read issued one cycle before the trigger: GRD first, fetch 2 cycles after trigger
        fork
            gl_txn("coll_prev", 1'b0, 3, 7, 3'b000, 1);
            begin
                @(posedge clk); #1; draw_x = 10'd640; draw_y = 10'd81;
                @(posedge clk); #1; draw_x = 10'd0; draw_y = 10'd0;
            end
            busy_start(fs_b);
        join
        chk("coll_prev_fetch_start", 32'(fs_b), 32'd3);
        repeat (14) @(posedge clk);
        #1;

        // Reset in the middle of a row 1 fetch
        for (int c = 0; c < 10; c++) gl_txn("pre1", 1'b1, 1, c, vals1[c], 0);
        trigger_line(95);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("k5_busy", 32'(fetch_busy), 32'd1);
        chk("k5_addr", 32'(ram_addr), 32'd15);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(fetch_busy), 32'd0);
        chk("midrst_color", 32'(color), 32'd0);
        chk("midrst_gl_ack", 32'(gl_ack), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) exp_lb[c] = 3'b000;
        pix(248, 97, exp_pix(248, 97));
        pix(296, 97, exp_pix(296, 97));
        pix(328, 97, exp_pix(328, 97));
        pix(392, 97, exp_pix(392, 97));

        // Refetch after reset
        trigger_line(95);
        repeat (13) @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) exp_lb[c] = ex_board[10 + c];
        for (int c = 0; c < 10; c++) pix(248 + 16 * c, 97, exp_pix(248 + 16 * c, 97));
        pix(240, 96, exp_pix(240, 96));

        repeat (3) @(posedge clk);
        #1;
        chk("gl_sb_drained", 32'(sb_gl.size()), 32'd0);
        chk("pix_sb_drained", 32'(sb_pix.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
